functional_unit_output_fifo: RTL and testbench
==============================================

Name: functional_unit_output_fifo

Overview:
- Parametrised successor to the single-entry functional unit output buffer.
- A DEPTH-entry FIFO of (value, ROB tag) results sits between any functional unit (ALU, AGU, branch) and the common data bus (CDB).
- Requests the CDB from the arbiter and drives the tri-state data/tag lines only when permitted.
- Supports a synchronous flush on misprediction and applies back-pressure to the FU, so the FU can keep executing while the CDB is contended.

Parameters:
- XLEN, 32, result data width.
- TAG_WIDTH, 32, ROB tag width.
- DEPTH, 4, number of FIFO entries; must be ≥ 2 and a power of two.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- value  input  XLEN  result from the FU.
- tag  input  TAG_WIDTH  ROB tag of the result.
- write_en  input  1  FU presents a result this cycle.
- write_ready  output  1  entry available this cycle: high when !full or a pop occurs this cycle; the FU's accept gates on this.
- full  output  1  count == DEPTH.
- not_empty  output  1  count != 0; also the CDB request line to the arbiter.
- count  output  $clog2(DEPTH+1)  occupancy.
- flush  input  1  discard all entries (branch mispredict).
- data_bus_permit  input  1  arbiter grant for this cycle.
- data_bus_valid  output  1  this block is driving the CDB this cycle.
- data_bus_data  output  XLEN  tri-state CDB data; 'Z when not driving.
- data_bus_tag  output  TAG_WIDTH  tri-state CDB tag; 'Z when not driving.

Behaviour:
- Storage:
  - Circular buffer with rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Separate count register.
- Reset (asynchronous, active-high):
  - rd_ptr = wr_ptr = count = 0.
  - Outputs: not_empty = 0, full = 0, write_ready = 1, data_bus_valid = 0, data_bus_data and data_bus_tag = 'Z.
  - Entry contents are don't-care.
- Pop condition: pop = data_bus_permit & not_empty & !flush.
  - Combinationally in the same cycle: data_bus_valid = 1, data_bus_data = mem[rd_ptr].value, data_bus_tag = mem[rd_ptr].tag.
  - On the next edge, rd_ptr advances.
- Push condition: push = write_en & write_ready & !flush.
  - On the next edge: mem[wr_ptr] ← (value, tag) and wr_ptr advances.
  - write_en while !write_ready: the write is ignored; the FU must hold its result.
- Count update: count += push − pop.
- Simultaneous push and pop at full: allowed; count stays DEPTH and both pointers advance.
- Simultaneous push and pop when count == 1: allowed; count stays 1.
- Flush (synchronous, highest priority):
  - On the next edge, pointers and count clear to 0.
  - In the flush cycle itself: data_bus_valid = 0, bus is 'Z, and write_en is dropped.
- data_bus_permit while empty: no drive and no state change; permit is not an error.
- Latency: a result pushed at edge N can appear on the bus at the earliest in cycle N+1 (zero-cycle path only when the optional feature is enabled).
- Order: strictly FIFO; results leave in write order.
- Reset asserted mid-operation: all entries are lost immediately and the bus is released asynchronously.

Optional Feature:
- Macro: OUTPUT_FIFO_BYPASS_EN.
- Defined:
  - When count == 0, write_en = 1, data_bus_permit = 1 and !flush: value and tag drive the CDB combinationally in the same cycle, data_bus_valid = 1, and nothing is stored.
  - not_empty is also asserted in that cycle (as value) so the arbiter sees the request.
- Not defined:
  - No combinational input-to-bus path exists; every result spends at least one cycle in the FIFO.

Test Plan:
- Reset, then push (value 0x10, tag 3) with permit = 0 → count = 1, bus 'Z. Next cycle permit = 1 → data_bus_data = 0x10, tag = 3, valid = 1; count = 0 next edge.
- DEPTH = 4: push 0xA1..0xA4 with permit = 0 → full = 1, write_ready = 0. Fifth write_en of 0xA5 is ignored. Then grant 4 cycles → bus shows 0xA1, 0xA2, 0xA3, 0xA4 in order.
- At full, write_en (0xB0) and permit in the same cycle → 0xA1 driven, 0xB0 stored, count stays 4. Pointer wrap is verified by draining and observing 0xB0 last.
- Fill with 3 entries, assert flush together with permit and write_en → bus 'Z, valid = 0 that cycle; count = 0 and not_empty = 0 next edge.
- Assert reset asynchronously mid-cycle with 2 entries and permit high → bus goes 'Z before the next edge; count = 0.
- With OUTPUT_FIFO_BYPASS_EN: empty FIFO, write_en with 0x55 / tag 7, permit = 1 → bus shows 0x55 / 7 in the same cycle, count remains 0. Without the macro: bus 'Z that cycle and 0x55 appears next cycle.

Source files
------------

// File: rtl/functional_unit_output_fifo.sv
`default_nettype none
// ============================================================================
// Module      : functional_unit_output_fifo
// Description : DEPTH-entry FIFO of (value, ROB tag) results between a
//               functional unit and the common data bus. It requests the CDB
//               and drives the tri-state lines only when granted. It also
//               handles mispredict flush and back-pressure to the FU.
//               Optional macro OUTPUT_FIFO_BYPASS_EN adds a same-cycle
//               input-to-bus path when the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module functional_unit_output_fifo #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 32,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [XLEN-1:0]              value,
    input  logic [TAG_WIDTH-1:0]         tag,
    input  logic                         write_en,
    output logic                         write_ready,
    output logic                         full,
    output logic                         not_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic                         flush,
    input  logic                         data_bus_permit,
    output logic                         data_bus_valid,
    output logic [XLEN-1:0]              data_bus_data,
    output logic [TAG_WIDTH-1:0]         data_bus_tag
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL_COUNT = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE    = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    logic [XLEN-1:0]      r_mem_value [DEPTH];
    logic [TAG_WIDTH-1:0] r_mem_tag   [DEPTH];
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_stored;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_bypass;
    logic                 w_drive;
    logic [XLEN-1:0]      w_bus_value;
    logic [TAG_WIDTH-1:0] w_bus_tag;

    assign w_stored = (r_count != '0);
    assign w_full   = (r_count == c_FULL_COUNT);

`ifdef OUTPUT_FIFO_BYPASS_EN
    // Empty FIFO with a grant: forward the FU result straight to the bus.
    assign w_bypass = !w_stored && write_en && data_bus_permit && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_pop   = data_bus_permit && w_stored && !flush;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign write_ready = !w_full || w_pop;
    assign w_push  = write_en && write_ready && !flush && !w_bypass;
    assign w_drive = w_pop || w_bypass;

    assign full           = w_full;
    assign not_empty      = w_stored || w_bypass;
    assign count          = r_count;
    assign data_bus_valid = w_drive;

    always_comb begin
        w_bus_value = r_mem_value[r_rd_ptr];
        w_bus_tag   = r_mem_tag[r_rd_ptr];
        if (w_bypass) begin
            w_bus_value = value;
            w_bus_tag   = tag;
        end
    end

    assign data_bus_data = w_drive ? w_bus_value : {XLEN{1'bz}};
    assign data_bus_tag  = w_drive ? w_bus_tag   : {TAG_WIDTH{1'bz}};

    // Entry storage carries no reset; contents are only meaningful via count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_value[r_wr_ptr] <= value;
            r_mem_tag[r_wr_ptr]   <= tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_functional_unit_output_fifo.sv
`default_nettype none
// Directed self-checking bench for functional_unit_output_fifo (DEPTH = 4).
module tb_functional_unit_output_fifo;

    localparam int XLEN      = 32;
    localparam int TAG_WIDTH = 32;
    localparam int DEPTH     = 4;

    logic              clk;
    logic              reset;
    logic [XLEN-1:0]   value;
    logic [TAG_WIDTH-1:0] tag;
    logic              write_en;
    logic              write_ready;
    logic              full;
    logic              not_empty;
    logic [2:0]        count;
    logic              flush;
    logic              data_bus_permit;
    logic              data_bus_valid;
    wire  [XLEN-1:0]   data_bus_data;
    wire  [TAG_WIDTH-1:0] data_bus_tag;

    int n_compared;
    int n_mismatched;

    functional_unit_output_fifo #(
        .XLEN      (XLEN),
        .TAG_WIDTH (TAG_WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .value           (value),
        .tag             (tag),
        .write_en        (write_en),
        .write_ready     (write_ready),
        .full            (full),
        .not_empty       (not_empty),
        .count           (count),
        .flush           (flush),
        .data_bus_permit (data_bus_permit),
        .data_bus_valid  (data_bus_valid),
        .data_bus_data   (data_bus_data),
        .data_bus_tag    (data_bus_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_bus(input string name);
        check({name, "_valid"}, 64'(data_bus_valid), 64'd0);
        check({name, "_data"},  64'(data_bus_data),  64'({XLEN{1'bz}}));
        check({name, "_tag"},   64'(data_bus_tag),   64'({TAG_WIDTH{1'bz}}));
    endtask

    task automatic check_bus(input string name, input logic [31:0] exp_v, input logic [31:0] exp_t);
        check({name, "_valid"}, 64'(data_bus_valid), 64'd1);
        check({name, "_data"},  64'(data_bus_data),  64'(exp_v));
        check({name, "_tag"},   64'(data_bus_tag),   64'(exp_t));
    endtask

    task automatic push(input logic [31:0] v, input logic [31:0] t);
        value    = v;
        tag      = t;
        write_en = 1'b1;
        cycle();
        write_en = 1'b0;
    endtask

    initial begin
        n_compared      = 0;
        n_mismatched    = 0;
        reset           = 1'b1;
        value           = '0;
        tag             = '0;
        write_en        = 1'b0;
        flush           = 1'b0;
        data_bus_permit = 1'b0;
        #1;
        // Reset state
        check("rst_count", 64'(count), 64'd0);
        check("rst_not_empty", 64'(not_empty), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_write_ready", 64'(write_ready), 64'd1);
        check_idle_bus("rst");
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // Permit while empty: no drive, no state change
        data_bus_permit = 1'b1;
        #1;
        check_idle_bus("empty_permit");
        cycle();
        data_bus_permit = 1'b0;
        check("empty_permit_count", 64'(count), 64'd0);

        // Single push, then grant one cycle later
        push(32'h10, 32'd3);
        check("t1_count", 64'(count), 64'd1);
        check("t1_not_empty", 64'(not_empty), 64'd1);
        check_idle_bus("t1_no_grant");
        data_bus_permit = 1'b1;
        #1;
        check_bus("t1_pop", 32'h10, 32'd3);
        cycle();
        data_bus_permit = 1'b0;
        check("t1_count_after", 64'(count), 64'd0);

        // Fill to DEPTH, overflow write ignored, drain in order
        for (int i = 1; i <= 4; i++) push(32'hA0 + 32'(i), 32'(i));
        check("t2_full", 64'(full), 64'd1);
        check("t2_write_ready", 64'(write_ready), 64'd0);
        check("t2_count", 64'(count), 64'd4);
        push(32'hA5, 32'd5);
        check("t2_overflow_count", 64'(count), 64'd4);
        data_bus_permit = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check_bus($sformatf("t2_drain%0d", i), 32'hA0 + 32'(i), 32'(i));
            cycle();
        end
        data_bus_permit = 1'b0;
        check("t2_empty", 64'(count), 64'd0);
        check("t2_not_empty", 64'(not_empty), 64'd0);

        // Simultaneous push and pop at full, then drain across the wrap
        for (int i = 1; i <= 4; i++) push(32'hA0 + 32'(i), 32'(i));
        value           = 32'hB0;
        tag             = 32'd11;
        write_en        = 1'b1;
        data_bus_permit = 1'b1;
        #1;
        check("t3_write_ready", 64'(write_ready), 64'd1);
        check_bus("t3_pop", 32'hA1, 32'd1);
        cycle();
        write_en = 1'b0;
        check("t3_count", 64'(count), 64'd4);
        for (int i = 2; i <= 4; i++) begin
            check_bus($sformatf("t3_drain%0d", i), 32'hA0 + 32'(i), 32'(i));
            cycle();
        end
        check_bus("t3_drain_b0", 32'hB0, 32'd11);
        cycle();
        data_bus_permit = 1'b0;
        check("t3_empty", 64'(count), 64'd0);

        // Flush with permit and write_en in the same cycle
        for (int i = 1; i <= 3; i++) push(32'hC0 + 32'(i), 32'(i));
        flush           = 1'b1;
        data_bus_permit = 1'b1;
        write_en        = 1'b1;
        value           = 32'hD0;
        tag             = 32'd9;
        #1;
        check_idle_bus("t4_flush");
        cycle();
        flush           = 1'b0;
        data_bus_permit = 1'b0;
        write_en        = 1'b0;
        check("t4_count", 64'(count), 64'd0);
        check("t4_not_empty", 64'(not_empty), 64'd0);

        // Asynchronous reset mid-cycle with 2 entries and permit high
        push(32'hE1, 32'd1);
        push(32'hE2, 32'd2);
        data_bus_permit = 1'b1;
        #1;
        check_bus("t5_before_reset", 32'hE1, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check_idle_bus("t5_reset");
        check("t5_count", 64'(count), 64'd0);
        data_bus_permit = 1'b0;
        cycle();
        reset = 1'b0;
        cycle();

        // Empty FIFO, write and permit together
        value           = 32'h55;
        tag             = 32'd7;
        write_en        = 1'b1;
        data_bus_permit = 1'b1;
        #1;
`ifdef OUTPUT_FIFO_BYPASS_EN
        check_bus("t6_bypass", 32'h55, 32'd7);
        check("t6_not_empty", 64'(not_empty), 64'd1);
        cycle();
        write_en        = 1'b0;
        data_bus_permit = 1'b0;
        check("t6_count", 64'(count), 64'd0);
`else
        check_idle_bus("t6_no_bypass");
        cycle();
        write_en = 1'b0;
        check("t6_count", 64'(count), 64'd1);
        check_bus("t6_next", 32'h55, 32'd7);
        cycle();
        data_bus_permit = 1'b0;
        check("t6_count_after", 64'(count), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
